// File: rtl/power_iter_ctrl.sv
// rtl/power_iter_ctrl.sv - power-iteration sequencer: seed, multiply, normalise, check, feedback
// Outputs are registered from the next-state decode, so each pulse coincides with its state.
module power_iter_ctrl #(
    parameter int SIZE_N   = 8,
    parameter int MAX_ITER = 32,
    parameter int ITER_W   = 6,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              seed_capture,
    output logic              vec_sel,
    output logic              mult_start,
    input  logic              mult_valid,
    output logic              norm_start,
    input  logic              norm_done,
    input  logic              converged,
    output logic              vec_we,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_count,
    output logic [1:0]        status
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_MULT, S_WAIT_M, S_NORM, S_WAIT_N, S_CHECK, S_DONE
    } state_t;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_CONV = 2'b01;
    localparam logic [1:0] ST_MAX  = 2'b10;
    localparam logic [1:0] ST_FAIL = 2'b11;

    // SIZE_N only sizes the datapath; nothing to build here for it.
    if (SIZE_N < 1 || MAX_ITER < 1) begin : g_param_range
    end

    state_t            state, state_d;
    logic [TO_W-1:0]   wd, wd_d, wd_inc;
    logic [ITER_W-1:0] iter_d, iter_inc;
    logic [1:0]        status_d;
    logic              vsel_d;

    assign wd_inc   = wd + 1'b1;
    assign iter_inc = iter_count + 1'b1;

    always_comb begin
        state_d  = state;
        wd_d     = wd;
        iter_d   = iter_count;
        status_d = status;
        vsel_d   = vec_sel;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_SEED;
                    iter_d   = '0;
                    status_d = ST_NONE;
                    vsel_d   = 1'b0;
                end
            end
            S_SEED: state_d = S_MULT;
            S_MULT: begin
                wd_d    = '0;
                state_d = S_WAIT_M;
            end
            S_WAIT_M: begin
                wd_d = wd_inc;
                if (mult_valid) begin
                    state_d = S_NORM;
                end else if (wd_inc == TO_W'(TIMEOUT)) begin
                    state_d  = S_DONE;
                    status_d = ST_FAIL;
                end
            end
            S_NORM: begin
                wd_d    = '0;
                state_d = S_WAIT_N;
            end
            S_WAIT_N: begin
                wd_d = wd_inc;
                if (norm_done) begin
                    state_d = S_CHECK;
                end else if (wd_inc == TO_W'(TIMEOUT)) begin
                    state_d  = S_DONE;
                    status_d = ST_FAIL;
                end
            end
            S_CHECK: begin
                iter_d = iter_inc;
                vsel_d = 1'b1;
                // On the first check the old vector is the random seed, so converged is meaningless.
                if (converged && iter_count != '0) begin
                    state_d  = S_DONE;
                    status_d = ST_CONV;
                end else if (iter_inc == ITER_W'(MAX_ITER)) begin
                    state_d  = S_DONE;
                    status_d = ST_MAX;
                end else begin
                    state_d = S_MULT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && state != S_IDLE && state != S_DONE) begin
            state_d  = S_DONE;
            status_d = ST_FAIL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            wd           <= '0;
            iter_count   <= '0;
            status       <= ST_NONE;
            vec_sel      <= 1'b0;
            seed_capture <= 1'b0;
            mult_start   <= 1'b0;
            norm_start   <= 1'b0;
            vec_we       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            wd           <= wd_d;
            iter_count   <= iter_d;
            status       <= status_d;
            vec_sel      <= vsel_d;
            seed_capture <= (state_d == S_SEED);
            mult_start   <= (state_d == S_MULT);
            norm_start   <= (state_d == S_NORM);
            vec_we       <= (state_d == S_CHECK);
            busy         <= (state_d != S_IDLE) && (state_d != S_DONE);
            done         <= (state_d == S_DONE) && (state != S_DONE);
        end
    end

endmodule

// File: tb/tb_power_iter_ctrl.sv
// tb/tb_power_iter_ctrl.sv - self-checking bench for power_iter_ctrl with datapath responder
module tb_power_iter_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, converged;
    logic       mv_resp, mv_stray, nd_resp, nd_stray;
    logic       mult_valid, norm_done;
    logic       seed_capture, vec_sel, mult_start, norm_start, vec_we, busy, done;
    logic [5:0] iter_count;
    logic [1:0] status;

    assign mult_valid = mv_resp | mv_stray;
    assign norm_done  = nd_resp | nd_stray;

    power_iter_ctrl #(.SIZE_N(8), .MAX_ITER(4), .ITER_W(6), .TIMEOUT(255), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .seed_capture(seed_capture), .vec_sel(vec_sel), .mult_start(mult_start),
        .mult_valid(mult_valid), .norm_start(norm_start), .norm_done(norm_done),
        .converged(converged), .vec_we(vec_we), .busy(busy), .done(done),
        .iter_count(iter_count), .status(status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mult_lat = 3;
    int norm_lat = 3;

    typedef struct {
        logic [1:0] st;
        logic [5:0] it;
        int         nm;
        int         nn;
        int         nw;
    } exp_t;
    exp_t sb[$];

    int   cyc = 0;
    int   n_seed = 0, n_mult = 0, n_norm = 0, n_we = 0, n_done = 0;
    int   mult_cyc = 0, done_cyc = 0, start_cyc = 0;
    logic vs_log[64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (seed_capture) n_seed++;
        if (mult_start) begin
            vs_log[n_mult % 64] = vec_sel;
            n_mult++;
            mult_cyc = cyc;
        end
        if (norm_start) n_norm++;
        if (vec_we) n_we++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // Datapath model: result pulse <lat> cycles after each launch; lat 0 means never.
    initial begin
        int mcnt, ncnt;
        mcnt = 0; ncnt = 0; mv_resp = 1'b0; nd_resp = 1'b0;
        forever begin
            @(negedge clk);
            mv_resp = 1'b0;
            nd_resp = 1'b0;
            if (mcnt > 0) begin mcnt--; if (mcnt == 0) mv_resp = 1'b1; end
            if (ncnt > 0) begin ncnt--; if (ncnt == 0) nd_resp = 1'b1; end
            if (mult_start && mult_lat > 0) mcnt = mult_lat;
            if (norm_start && norm_lat > 0) ncnt = norm_lat;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic start_run();
        @(negedge clk);
        #1;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; converged = 1'b0;
        mv_stray = 1'b0; nd_stray = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({seed_capture, mult_start, norm_start, vec_we, busy, done, vec_sel, status, iter_count} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got sc=%b ms=%b ns=%b we=%b busy=%b done=%b vs=%b st=%b it=%0d want all 0",
                     seed_capture, mult_start, norm_start, vec_we, busy, done, vec_sel, status, iter_count);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_max_iter();
        int bs, bm, bn, bw, bd;
        bit ok;
        exp_t e;
        converged = 1'b0; mult_lat = 3; norm_lat = 3;
        bs = n_seed; bm = n_mult; bn = n_norm; bw = n_we; bd = n_done;
        sb.push_back('{st: 2'b10, it: 6'd4, nm: 4, nn: 4, nw: 4});
        start_run();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL max_busy_during got %b want 1", busy); end
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL max_done_timeout got no done want done"); end
        e = sb.pop_front();
        checks++;
        if (status !== e.st) begin errors++; $display("FAIL max_status got %b want %b", status, e.st); end
        checks++;
        if (iter_count !== e.it) begin errors++; $display("FAIL max_iter got %0d want %0d", iter_count, e.it); end
        checks++;
        if (n_mult - bm != e.nm || n_norm - bn != e.nn || n_we - bw != e.nw) begin
            errors++;
            $display("FAIL max_pulses got m=%0d n=%0d w=%0d want %0d %0d %0d",
                     n_mult - bm, n_norm - bn, n_we - bw, e.nm, e.nn, e.nw);
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (n_seed - bs != 1 || n_done - bd != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL max_seed_done_busy got seed=%0d done=%0d busy=%b want 1 1 0",
                     n_seed - bs, n_done - bd, busy);
        end
    endtask

    task automatic test_converge();
        int bm;
        bit ok;
        exp_t e;
        converged = 1'b1; mult_lat = 3; norm_lat = 3;
        bm = n_mult;
        sb.push_back('{st: 2'b01, it: 6'd2, nm: 2, nn: 2, nw: 2});
        start_run();
        wait_done(200, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || status !== e.st || iter_count !== e.it) begin
            errors++;
            $display("FAIL conv_result got ok=%b st=%b it=%0d want 1 %b %0d", ok, status, iter_count, e.st, e.it);
        end
        checks++;
        if (n_mult - bm != e.nm) begin errors++; $display("FAIL conv_mults got %0d want %0d", n_mult - bm, e.nm); end
        checks++;
        if (vs_log[bm % 64] !== 1'b0 || vs_log[(bm + 1) % 64] !== 1'b1) begin
            errors++;
            $display("FAIL conv_vec_sel got %b,%b want 0,1", vs_log[bm % 64], vs_log[(bm + 1) % 64]);
        end
        converged = 1'b0;
    endtask

    task automatic test_min_run();
        bit ok;
        exp_t e;
        converged = 1'b1; mult_lat = 1; norm_lat = 1;
        sb.push_back('{st: 2'b01, it: 6'd2, nm: 2, nn: 2, nw: 2});
        start_run();
        wait_done(50, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || done_cyc - start_cyc != 12) begin
            errors++;
            $display("FAIL min_run_latency got ok=%b lat=%0d want 1 12", ok, done_cyc - start_cyc);
        end
        checks++;
        if (status !== e.st || iter_count !== e.it) begin
            errors++;
            $display("FAIL min_run_result got st=%b it=%0d want %b %0d", status, iter_count, e.st, e.it);
        end
        converged = 1'b0; mult_lat = 3; norm_lat = 3;
    endtask

    task automatic test_timeout();
        int bn;
        bit ok;
        exp_t e;
        converged = 1'b0; mult_lat = 0; norm_lat = 3;
        bn = n_norm;
        sb.push_back('{st: 2'b11, it: 6'd0, nm: 1, nn: 0, nw: 0});
        start_run();
        wait_done(400, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || done_cyc - mult_cyc != 256) begin
            errors++;
            $display("FAIL timeout_latency got ok=%b cycles=%0d want 1 256", ok, done_cyc - mult_cyc);
        end
        checks++;
        if (status !== e.st || iter_count !== e.it || n_norm - bn != e.nn) begin
            errors++;
            $display("FAIL timeout_result got st=%b it=%0d norm=%0d want %b %0d %0d",
                     status, iter_count, n_norm - bn, e.st, e.it, e.nn);
        end
        mult_lat = 3;
    endtask

    task automatic test_coincident();
        int bn;
        bit ok;
        exp_t e;
        converged = 1'b1; mult_lat = 255; norm_lat = 3;
        bn = n_norm;
        sb.push_back('{st: 2'b01, it: 6'd2, nm: 2, nn: 2, nw: 2});
        start_run();
        wait_done(1200, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || status !== e.st || iter_count !== e.it || n_norm - bn != e.nn) begin
            errors++;
            $display("FAIL coincident_result got ok=%b st=%b it=%0d norm=%0d want 1 %b %0d %0d",
                     ok, status, iter_count, n_norm - bn, e.st, e.it, e.nn);
        end
        converged = 1'b0; mult_lat = 3;
    endtask

    task automatic test_abort();
        int bw, bd;
        bit seen;
        exp_t e;
        converged = 1'b0; mult_lat = 3; norm_lat = 3;
        bw = n_we; bd = n_done;
        sb.push_back('{st: 2'b11, it: 6'd0, nm: 1, nn: 1, nw: 0});
        start_run();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (norm_start) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_norm_start got none want pulse"); end
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        #1;
        abort = 1'b0;
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || vec_we !== 1'b0 || status !== e.st) begin
            errors++;
            $display("FAIL abort_next_cycle got done=%b we=%b st=%b want 1 0 %b", done, vec_we, status, e.st);
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (n_we - bw != e.nw || n_done - bd != 1 || iter_count !== e.it || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_after got we=%0d done=%0d it=%0d busy=%b want %0d 1 %0d 0",
                     n_we - bw, n_done - bd, iter_count, busy, e.nw, e.it);
        end
    endtask

    task automatic test_reset_mid();
        int bd;
        bit seen;
        converged = 1'b0; mult_lat = 3; norm_lat = 3;
        bd = n_done;
        start_run();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (norm_start) begin seen = 1'b1; break; end
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (!seen || {seed_capture, mult_start, norm_start, vec_we, busy, done, vec_sel, status, iter_count} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_async got seen=%b busy=%b vs=%b st=%b it=%0d want 1 0 0 0 0",
                     seen, busy, vec_sel, status, iter_count);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (n_done - bd != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done got done=%0d busy=%b want 0 0", n_done - bd, busy);
        end
    endtask

    task automatic test_stray_and_busy_start();
        int bs, bm, bn, bw, bd;
        bit ok;
        exp_t e;
        bs = n_seed; bm = n_mult; bn = n_norm; bw = n_we;
        @(negedge clk);
        mv_stray = 1'b1; nd_stray = 1'b1;
        @(negedge clk);
        mv_stray = 1'b0; nd_stray = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || n_seed != bs || n_mult != bm || n_norm != bn || n_we != bw) begin
            errors++;
            $display("FAIL stray_idle got busy=%b pulses=%0d want 0 0", busy,
                     (n_seed - bs) + (n_mult - bm) + (n_norm - bn) + (n_we - bw));
        end
        converged = 1'b1; mult_lat = 3; norm_lat = 3;
        bs = n_seed; bd = n_done;
        sb.push_back('{st: 2'b01, it: 6'd2, nm: 2, nn: 2, nw: 2});
        start_run();
        @(negedge clk);
        start = 1'b1;
        repeat (8) @(negedge clk);
        start = 1'b0;
        wait_done(100, ok);
        e = sb.pop_front();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (!ok || status !== e.st || iter_count !== e.it || n_seed - bs != 1 || n_done - bd != 1) begin
            errors++;
            $display("FAIL busy_start got ok=%b st=%b it=%0d seed=%0d done=%0d want 1 %b %0d 1 1",
                     ok, status, iter_count, n_seed - bs, n_done - bd, e.st, e.it);
        end
        converged = 1'b0;
    endtask

    initial begin
        test_reset();
        test_max_iter();
        test_converge();
        test_min_run();
        test_timeout();
        test_coincident();
        test_abort();
        test_reset_mid();
        test_stray_and_busy_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/power_iter_ctrl.md
Name: power_iter_ctrl

Overview:
- Sequencer for the eigenvector power-iteration loop built around the shared double-precision matrix-vector multiplier (SIZE_N x SIZE_N by SIZE_N x 1) and the vector normaliser.
- Captures a random seed vector from the LFSR bank, repeatedly launches multiply, then normalise, then a convergence check, and writes the feedback vector.
- Terminates on convergence, on iteration limit, on watchdog timeout or on abort, and reports status to the top-level decomposition FSM.

Parameters:
SIZE_N, 8, vector length; informational only, passed through to the datapath; no effect on control timing
MAX_ITER, 32, maximum multiply/normalise iterations per run (1..2^ITER_W-1)
ITER_W, 6, width of iteration counter
TIMEOUT, 255, max cycles waiting on mult_valid or norm_done before abort
TO_W, 8, width of watchdog counter (TIMEOUT < 2^TO_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin run; sampled only in IDLE/DONE
abort  in  1  synchronous abort request, any state
seed_capture  out  1  1-cycle pulse: latch LFSR vector into the seed register
vec_sel  out  1  multiplier vector source: 0 = seed register, 1 = feedback register
mult_start  out  1  1-cycle pulse launching the matrix-vector multiply
mult_valid  in  1  multiplier result ready (1-cycle pulse)
norm_start  out  1  1-cycle pulse launching normalisation of the multiply result
norm_done  in  1  normaliser result ready (1-cycle pulse)
converged  in  1  comparator output: old vs new vector within tolerance; sampled in CHECK only
vec_we  out  1  1-cycle pulse: write normalised vector into the feedback register
busy  out  1  high in every state except IDLE and DONE
done  out  1  1-cycle pulse on entry to DONE
iter_count  out  ITER_W  completed iterations in current/last run
status  out  2  00 none, 01 converged, 10 max iterations, 11 timeout or abort

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, iter_count = 0, watchdog = 0, status = 00, vec_sel = 0; all pulse outputs and busy are 0.
- All outputs are registered.
- States: IDLE, SEED, MULT, WAIT_M, NORM, WAIT_N, CHECK, DONE.
- IDLE/DONE: on start = 1 go to SEED.
  - Clear iter_count, status and vec_sel on that same edge.
  - DONE holds iter_count and status until the next start.
- SEED: seed_capture = 1 for one cycle; then go to MULT.
- MULT: mult_start = 1 for one cycle; clear watchdog; then go to WAIT_M.
- WAIT_M:
  - Watchdog increments each cycle.
  - mult_valid = 1 -> NORM.
  - Watchdog reaching TIMEOUT with no mult_valid -> DONE with status 11.
  - mult_valid arriving in the same cycle the watchdog reaches TIMEOUT wins (go to NORM).
- NORM: norm_start = 1 for one cycle; clear watchdog; then go to WAIT_N.
- WAIT_N: same watchdog rules as WAIT_M, using norm_done; then go to CHECK.
- CHECK: vec_we = 1 for one cycle, iter_count increments, vec_sel set to 1. Then:
  - converged = 1 -> DONE, status 01.
  - else incremented iter_count == MAX_ITER -> DONE, status 10.
  - else -> MULT.
  - Convergence takes priority over the iteration limit.
- The first CHECK after SEED ignores converged, because the old vector is the random seed.
- abort = 1 in any busy state: next state DONE, status 11.
  - Pending pulses are suppressed: no mult_start, norm_start or vec_we is issued in the abort cycle or after it.
- done pulses exactly once per run, in the cycle after the transition into DONE is decided.
- Stray mult_valid or norm_done outside its wait state is ignored.
- start while busy is ignored.
- Minimum run, converging on the 2nd iteration, with 1-cycle datapath latency: start at cycle 0, done at cycle 12.
- Reset asserted mid-run: immediate return to IDLE; no done pulse.

Test Plan:
- Reset, then start; mult_valid and norm_done returned 3 cycles after each launch pulse; converged = 0 throughout, MAX_ITER = 4 -> exactly 4 mult_start and 4 vec_we pulses, one seed_capture, status = 10, iter_count = 4, one done pulse, busy low afterwards.
- converged = 1 from the start -> first CHECK ignores it; run stops at iteration 2 with status = 01, iter_count = 2; vec_sel is 0 during the first multiply and 1 during the second.
- mult_valid never returned -> after 255 cycles in WAIT_M: done, status = 11, iter_count = 0, no norm_start issued.
- mult_valid coincident with the watchdog reaching 255 -> NORM entered, run continues, no timeout reported.
- abort asserted in the cycle before CHECK -> no vec_we; done next cycle; status = 11.
- rst pulled low mid-WAIT_N -> all outputs 0 asynchronously and no done pulse. start while busy and a stray norm_done in IDLE -> no effect.
